// File: rtl/fifo_pkg.sv
// fifo_pkg: shared helpers and parameter legality checks for the FIFO family
package fifo_pkg;

    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic bit params_ok(input int depth, input int af, input int ae);
        return depth >= 2 && (depth & (depth - 1)) == 0 &&
               af >= 1 && af <= depth && ae >= 0 && ae <= depth - 1;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: simple dual-port storage with synchronous write and registered read
module sync_fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    // storage is deliberately left out of reset so it can map onto RAM
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/param_sync_fifo.sv
// param_sync_fifo: single-clock FIFO with occupancy, threshold flags and error pulses
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int AW        = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] din,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [AW:0]       count,
    output logic              overflow,
    output logic              underflow
);
    localparam int  CW        = AW + 1;
    localparam bit  PARAMS_OK = params_ok(DEPTH, AF_THRESH, AE_THRESH);

    logic [AW:0] wr_ptr, rd_ptr;
    logic        wr_ok, rd_ok;

    always_ff @(posedge clk) assert (PARAMS_OK);

    // extra wrap bit distinguishes full from empty when the low bits match
    always_comb begin
        empty        = wr_ptr == rd_ptr;
        full         = wr_ptr[AW-1:0] == rd_ptr[AW-1:0] && wr_ptr[AW] != rd_ptr[AW];
        count        = wr_ptr - rd_ptr;
        almost_full  = count >= CW'(AF_THRESH);
        almost_empty = count <= CW'(AE_THRESH);
        wr_ok        = wr_en && !full && !rst;
        rd_ok        = rd_en && !empty && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ptr    <= wr_ok ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr    <= rd_ok ? rd_ptr + 1'b1 : rd_ptr;
            overflow  <= wr_en && full;
            underflow <= rd_en && empty;
        end
    end

    sync_fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_ok),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (din),
        .re    (rd_ok),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (dout)
    );
endmodule

// File: tb/tb_param_sync_fifo.sv
// tb_param_sync_fifo: randomized scenarios against a queue-based reference model
module tb_param_sync_fifo;
    logic       clk = 0;
    logic       rst = 0;
    logic       wr_en = 0;
    logic       rd_en = 0;
    logic [7:0] din = 0;
    logic [7:0] dout;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0] count;

    int total = 0;
    int bad = 0;

    logic [7:0] q[$];
    logic [7:0] m_dout = 0;
    logic       m_ovf = 0;
    logic       m_unf = 0;

    param_sync_fifo dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .din          (din),
        .rd_en        (rd_en),
        .dout         (dout),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] exp_status();
        int n = q.size();
        return {n == 16, n == 0, n >= 14, n <= 2, 5'(n)};
    endfunction

    task automatic drive(input bit w, input bit r, input logic [7:0] d, input bit rs = 0);
        int n;
        wr_en = w;
        rd_en = r;
        din   = d;
        rst   = rs;
        @(posedge clk);
        n = q.size();
        if (rs) begin
            q.delete();
            m_dout = 0;
            m_ovf  = 0;
            m_unf  = 0;
        end else begin
            m_ovf = w && n == 16;
            m_unf = r && n == 0;
            if (r && n > 0) m_dout = q.pop_front();
            if (w && n < 16) q.push_back(d);
        end
        #1;
        wr_en = 0;
        rd_en = 0;
        rst   = 0;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 1);
        total++;
        if ({full, empty, almost_full, almost_empty, count} !== 9'b0_1_0_1_00000) begin
            bad++; $display("FAIL reset_status: got %b want %b", {full, empty, almost_full, almost_empty, count}, 9'b010100000);
        end
        total++;
        if (dout !== 8'h00) begin bad++; $display("FAIL reset_dout: got %h want 00", dout); end
        drive(0, 0, 0);
        total++;
        if ({overflow, underflow} !== 2'b00) begin bad++; $display("FAIL reset_err: got %b want 00", {overflow, underflow}); end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 16; i++) begin
            drive(1, 0, 8'(i));
            total++;
            if ({full, empty, almost_full, almost_empty, count} !== exp_status()) begin
                bad++; $display("FAIL fill_status[%0d]: got %b want %b", i, {full, empty, almost_full, almost_empty, count}, exp_status());
            end
        end
        total++;
        if (full !== 1'b1) begin bad++; $display("FAIL fill_full: got %b want 1", full); end
        for (int i = 0; i < 16; i++) begin
            drive(0, 1, 0);
            total++;
            if (dout !== 8'(i) || dout !== m_dout) begin
                bad++; $display("FAIL drain_dout[%0d]: got %h want %h", i, dout, 8'(i));
            end
            total++;
            if ({full, empty, almost_full, almost_empty, count} !== exp_status()) begin
                bad++; $display("FAIL drain_status[%0d]: got %b want %b", i, {full, empty, almost_full, almost_empty, count}, exp_status());
            end
        end
        total++;
        if (empty !== 1'b1) begin bad++; $display("FAIL drain_empty: got %b want 1", empty); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 16; i++) drive(1, 0, 8'($urandom_range(0, 127)));
        drive(1, 1, 8'hAA);
        total++;
        if (overflow !== 1'b1 || count !== 5'd15) begin
            bad++; $display("FAIL overflow_pulse: got ovf=%b count=%0d want ovf=1 count=15", overflow, count);
        end
        total++;
        if (dout !== m_dout) begin bad++; $display("FAIL overflow_dout: got %h want %h", dout, m_dout); end
        drive(0, 0, 0);
        total++;
        if (overflow !== 1'b0) begin bad++; $display("FAIL overflow_once: got %b want 0", overflow); end
        while (q.size() > 0) begin
            drive(0, 1, 0);
            total++;
            if (dout !== m_dout || dout === 8'hAA) begin
                bad++; $display("FAIL overflow_drain: got %h want %h", dout, m_dout);
            end
        end
    endtask

    task automatic test_underflow();
        drive(1, 1, 8'h55);
        total++;
        if (underflow !== 1'b1 || count !== 5'd1 || overflow !== 1'b0) begin
            bad++; $display("FAIL underflow_pulse: got unf=%b count=%0d want unf=1 count=1", underflow, count);
        end
        drive(0, 1, 0);
        total++;
        if (dout !== 8'h55 || underflow !== 1'b0) begin
            bad++; $display("FAIL underflow_read: got dout=%h unf=%b want dout=55 unf=0", dout, underflow);
        end
        drive(0, 1, 0);
        total++;
        if (underflow !== 1'b1 || dout !== 8'h55) begin
            bad++; $display("FAIL underflow_hold: got unf=%b dout=%h want unf=1 dout=55", underflow, dout);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) drive(1, 0, 8'($urandom));
        for (int i = 0; i < 40; i++) begin
            drive(1, 1, 8'($urandom));
            total++;
            if (dout !== m_dout || count !== 5'd5) begin
                bad++; $display("FAIL b2b[%0d]: got dout=%h count=%0d want dout=%h count=5", i, dout, count, m_dout);
            end
        end
        while (q.size() > 0) drive(0, 1, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 50), 8'($urandom));
            total++;
            if ({full, empty, almost_full, almost_empty, count, dout, overflow, underflow} !==
                {exp_status(), m_dout, m_ovf, m_unf}) begin
                bad++; $display("FAIL random[%0d]: got %b/%h/%b%b want %b/%h/%b%b", i,
                    {full, empty, almost_full, almost_empty, count}, dout, overflow, underflow,
                    exp_status(), m_dout, m_ovf, m_unf);
            end
        end
    endtask

    task automatic test_reset_flush();
        while (q.size() > 0) drive(0, 1, 0);
        for (int i = 0; i < 9; i++) drive(1, 0, 8'($urandom));
        drive(0, 1, 0);
        drive(1, 0, 8'h11);
        drive(1, 0, 8'h77, 1);
        total++;
        if (count !== 5'd0 || empty !== 1'b1 || dout !== 8'h00) begin
            bad++; $display("FAIL flush: got count=%0d empty=%b dout=%h want 0/1/00", count, empty, dout);
        end
        drive(1, 0, 8'h3C);
        drive(0, 1, 0);
        total++;
        if (dout !== 8'h3C || empty !== 1'b1) begin
            bad++; $display("FAIL flush_reuse: got dout=%h empty=%b want 3c/1", dout, empty);
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow();
        test_underflow();
        test_back_to_back();
        test_random();
        test_reset_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
